// File: rtl/spio_pkt_link_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : spio_pkt_link_arbiter
// Description : Two-input valid/ready packet arbiter with a single registered
//               output stage. The arbiter is round-robin or fixed-priority.
//               Defining SPIO_ARB_PKT_CNT_EN builds saturating per-port
//               packet counters.
// Revision    : 1.0 - initial release
// ============================================================================
module spio_pkt_link_arbiter #(
  parameter int PKT_BITS = 72,
  parameter int CNT_BITS = 16
) (
  input  logic                clk,
  input  logic                nreset,
  input  logic [PKT_BITS-1:0] in0_data,
  input  logic                in0_vld,
  output logic                in0_rdy,
  input  logic [PKT_BITS-1:0] in1_data,
  input  logic                in1_vld,
  output logic                in1_rdy,
  output logic [PKT_BITS-1:0] out_data,
  output logic                out_vld,
  input  logic                out_rdy,
  input  logic                prio_sel,
  input  logic                cnt_clr,
  output logic [CNT_BITS-1:0] cnt0,
  output logic [CNT_BITS-1:0] cnt1
);

  logic [PKT_BITS-1:0] r_out_data;
  logic                r_out_vld;
  logic                r_last;
  logic                w_load;
  logic                w_grant0;
  logic                w_grant1;
  logic                w_acc0;
  logic                w_acc1;

  assign w_load = !r_out_vld || out_rdy;

  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if (in0_vld && in1_vld) begin
      if (prio_sel || r_last) w_grant0 = 1'b1;
      else                    w_grant1 = 1'b1;
    end else if (in0_vld) begin
      w_grant0 = 1'b1;
    end else if (in1_vld) begin
      w_grant1 = 1'b1;
    end
  end

  // Grants already imply vld, so a ready never appears without a transfer.
  assign w_acc0  = w_grant0 && w_load && nreset;
  assign w_acc1  = w_grant1 && w_load && nreset;
  assign in0_rdy = w_acc0;
  assign in1_rdy = w_acc1;

  always_ff @(posedge clk) begin
    if (!nreset) begin
      r_out_data <= '0;
      r_out_vld  <= 1'b0;
      r_last     <= 1'b1;
    end else if (w_acc0) begin
      r_out_data <= in0_data;
      r_out_vld  <= 1'b1;
      r_last     <= 1'b0;
    end else if (w_acc1) begin
      r_out_data <= in1_data;
      r_out_vld  <= 1'b1;
      r_last     <= 1'b1;
    end else if (out_rdy) begin
      r_out_vld  <= 1'b0;
    end
  end

  assign out_data = r_out_data;
  assign out_vld  = r_out_vld;

`ifdef SPIO_ARB_PKT_CNT_EN
  logic [CNT_BITS-1:0] r_cnt0;
  logic [CNT_BITS-1:0] r_cnt1;
  localparam logic [CNT_BITS-1:0] c_ONE = {{(CNT_BITS-1){1'b0}}, 1'b1};

  // Clear beats increment; counters stick at all-ones.
  always_ff @(posedge clk) begin
    if (!nreset || cnt_clr) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else begin
      if (w_acc0 && (r_cnt0 != '1)) r_cnt0 <= r_cnt0 + c_ONE;
      if (w_acc1 && (r_cnt1 != '1)) r_cnt1 <= r_cnt1 + c_ONE;
    end
  end

  assign cnt0 = r_cnt0;
  assign cnt1 = r_cnt1;
`else
  logic w_unused_cnt_clr;
  assign w_unused_cnt_clr = cnt_clr;
  assign cnt0 = '0;
  assign cnt1 = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_spio_pkt_link_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_spio_pkt_link_arbiter
// Description : Self-checking bench; a queue-based reference of the output
//               stage predicts grants, delivered packets and counters.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spio_pkt_link_arbiter;

  localparam int c_PKT_BITS = 72;
  localparam int c_CNT_BITS = 4;
  localparam int c_CNT_MAX  = (1 << c_CNT_BITS) - 1;

  logic                  clk = 1'b0;
  logic                  nreset;
  logic [c_PKT_BITS-1:0] in0_data, in1_data, out_data;
  logic                  in0_vld, in1_vld, in0_rdy, in1_rdy;
  logic                  out_vld, out_rdy, prio_sel, cnt_clr;
  logic [c_CNT_BITS-1:0] cnt0, cnt1;

  int checks = 0;
  int errors = 0;

  logic [c_PKT_BITS-1:0] q_exp[$];
  logic                  m_last;
  int                    m_cnt0, m_cnt1;
  int                    pkt_id = 0;

  spio_pkt_link_arbiter #(.PKT_BITS(c_PKT_BITS), .CNT_BITS(c_CNT_BITS)) u_dut (
    .clk(clk), .nreset(nreset),
    .in0_data(in0_data), .in0_vld(in0_vld), .in0_rdy(in0_rdy),
    .in1_data(in1_data), .in1_vld(in1_vld), .in1_rdy(in1_rdy),
    .out_data(out_data), .out_vld(out_vld), .out_rdy(out_rdy),
    .prio_sel(prio_sel), .cnt_clr(cnt_clr), .cnt0(cnt0), .cnt1(cnt1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [c_PKT_BITS-1:0] act,
                     input logic [c_PKT_BITS-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", tag, act, exp);
    end
  endtask

  function automatic logic [c_PKT_BITS-1:0] exp_cnt(input int v);
`ifdef SPIO_ARB_PKT_CNT_EN
    return c_PKT_BITS'(v);
`else
    return '0;
`endif
  endfunction

  // Fresh distinct packets: top byte tags the port, low bits a sequence id.
  task automatic new_data();
    pkt_id++;
    in0_data = {8'h0A, 32'h0, 32'(pkt_id)};
    in1_data = {8'h0B, 32'h0, 32'(pkt_id)};
  endtask

  // One cycle: check DUT against the reference at negedge, then advance both.
  task automatic step();
    logic load, g0, g1, e0, e1;
    @(negedge clk);
    load = (q_exp.size() == 0) || out_rdy;
    g0 = 1'b0;
    g1 = 1'b0;
    if (in0_vld && in1_vld) begin
      if (prio_sel || m_last) g0 = 1'b1; else g1 = 1'b1;
    end else begin
      g0 = in0_vld;
      g1 = in1_vld;
    end
    e0 = g0 && load && nreset;
    e1 = g1 && load && nreset;
    chk("in0_rdy", c_PKT_BITS'(in0_rdy), c_PKT_BITS'(e0));
    chk("in1_rdy", c_PKT_BITS'(in1_rdy), c_PKT_BITS'(e1));
    chk("out_vld", c_PKT_BITS'(out_vld), c_PKT_BITS'(q_exp.size() != 0));
    chk("cnt0", c_PKT_BITS'(cnt0), exp_cnt(m_cnt0));
    chk("cnt1", c_PKT_BITS'(cnt1), exp_cnt(m_cnt1));
    if (q_exp.size() != 0) begin
      if (out_rdy) chk("out_data", out_data, q_exp.pop_front());
      else         chk("out_hold", out_data, q_exp[0]);
    end
    if (!nreset) begin
      q_exp.delete();
      m_last = 1'b1;
      m_cnt0 = 0;
      m_cnt1 = 0;
    end else begin
      if (e0) begin q_exp.push_back(in0_data); m_last = 1'b0; end
      if (e1) begin q_exp.push_back(in1_data); m_last = 1'b1; end
      if (cnt_clr) begin
        m_cnt0 = 0;
        m_cnt1 = 0;
      end else begin
        if (e0 && m_cnt0 < c_CNT_MAX) m_cnt0++;
        if (e1 && m_cnt1 < c_CNT_MAX) m_cnt1++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    nreset = 1'b0; in0_vld = 1'b1; in1_vld = 1'b1; out_rdy = 1'b0;
    prio_sel = 1'b0; cnt_clr = 1'b0; in0_data = '0; in1_data = '0;
    m_last = 1'b1; m_cnt0 = 0; m_cnt1 = 0;
    new_data();
    @(posedge clk); #1;

    // Reset held with both requesters valid.
    repeat (3) step();
    chk("rst_data", out_data, '0);

    // Round-robin streaming, port 0 first.
    nreset = 1'b1; out_rdy = 1'b1;
    @(negedge clk);
    chk("first_grant0", c_PKT_BITS'(in0_rdy), c_PKT_BITS'(1));
    @(posedge clk); #1;
    // that edge accepted port 0 outside step(); mirror it in the reference
    q_exp.push_back(in0_data); m_last = 1'b0; m_cnt0 = 1;
    for (int i = 0; i < 7; i++) begin new_data(); step(); end
    chk("rr_cnt0", c_PKT_BITS'(cnt0), exp_cnt(4));
    chk("rr_cnt1", c_PKT_BITS'(cnt1), exp_cnt(4));

    // Fixed priority: only port 0 while both valid.
    cnt_clr = 1'b1; in0_vld = 1'b0; in1_vld = 1'b0; step();
    cnt_clr = 1'b0; prio_sel = 1'b1; in0_vld = 1'b1; in1_vld = 1'b1;
    for (int i = 0; i < 5; i++) begin new_data(); step(); end
    chk("fp_cnt0", c_PKT_BITS'(cnt0), exp_cnt(5));
    chk("fp_cnt1", c_PKT_BITS'(cnt1), exp_cnt(0));
    in0_vld = 1'b0; new_data(); step();
    chk("fp_port1", c_PKT_BITS'(cnt1), exp_cnt(1));

    // Backpressure: stage full, out_rdy low, both valid.
    in1_vld = 1'b0; step();
    in0_vld = 1'b1; new_data(); step();
    out_rdy = 1'b0; in1_vld = 1'b1; prio_sel = 1'b0;
    for (int i = 0; i < 4; i++) begin new_data(); step(); end
    out_rdy = 1'b1; step();
    in0_vld = 1'b0; in1_vld = 1'b0; step();
    step();

    // Counter saturation, then clear coinciding with an acceptance.
    cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
    in0_vld = 1'b1;
    for (int i = 0; i < 17; i++) begin new_data(); step(); end
    chk("sat_cnt0", c_PKT_BITS'(cnt0), exp_cnt(15));
    cnt_clr = 1'b1; new_data(); step(); cnt_clr = 1'b0;
    chk("clr_cnt0", c_PKT_BITS'(cnt0), exp_cnt(0));

    // Reset while a packet is held under backpressure.
    in0_vld = 1'b0; step();
    in1_vld = 1'b1; new_data(); step();
    out_rdy = 1'b0; in1_vld = 1'b0; step();
    nreset = 1'b0; step();
    nreset = 1'b1; out_rdy = 1'b1;
    chk("mid_rst_vld", c_PKT_BITS'(out_vld), c_PKT_BITS'(0));
    chk("mid_rst_data", out_data, '0);
    repeat (2) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
